spi_byte_serialiser: RTL and testbench



---
 rtl/spi_ser_pkg.sv | 26 ++
 rtl/spi_half_period_timer.sv | 41 ++++
 rtl/spi_byte_serialiser.sv | 150 +++++++++++++++
 tb/tb_spi_byte_serialiser.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_ser_pkg.sv
// -----------------------------------------------------------------------------
// spi_ser_pkg
// Shared definitions for the SPI byte serialiser:
//   - state_e        : serialiser FSM states
//   - DEF_DATA_WIDTH : default bits per frame
//   - DEF_HALF_PERIOD: default clk_in cycles per SCLK half-period
//   - cnt_width()    : register width able to hold the values 0..n-1 (min 1 bit)
// -----------------------------------------------------------------------------
package spi_ser_pkg;

    localparam int DEF_DATA_WIDTH  = 8;
    localparam int DEF_HALF_PERIOD = 1;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SHIFT_LOW  = 2'd1,
        SHIFT_HIGH = 2'd2,
        GAP        = 2'd3
    } state_e;

    // $clog2(1) is 0, so clamp to one bit to keep every counter a legal vector.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_half_period_timer.sv
// -----------------------------------------------------------------------------
// spi_half_period_timer
// Counts HALF_PERIOD enabled clk_in cycles and pulses tick_o on the last one,
// then wraps so consecutive half-periods follow without a dead cycle.
// Ports:
//   clk_in   : system clock, rising edge
//   rst_in   : synchronous active-high reset
//   clear_i  : restart the count (frame start)
//   en_i     : count this cycle
//   tick_o   : high during the final cycle of a half-period (combinational)
// -----------------------------------------------------------------------------
module spi_half_period_timer
    import spi_ser_pkg::*;
#(
    parameter int HALF_PERIOD = DEF_HALF_PERIOD
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic clear_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int CNT_W = cnt_width(HALF_PERIOD);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(HALF_PERIOD - 1);

    logic [CNT_W-1:0] cnt_q;

    assign tick_o = en_i && (cnt_q == LAST);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_in) begin
        if (rst_in || clear_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= tick_o ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/spi_byte_serialiser.sv
// -----------------------------------------------------------------------------
// spi_byte_serialiser
// Write-only SPI mode-0 master transmitter. Shifts a DATA_WIDTH-bit word out
// MSB-first on data_out, generating clk_out (idles low) and an active-low
// chip enable. data_out only changes while clk_out is low, so it is stable on
// every rising clk_out edge. One idle-high GAP cycle separates frames.
// Ports:
//   clk_in        : system clock, rising edge
//   rst_in        : synchronous active-high reset, aborts any frame
//   send_data     : transfer request (level)
//   data_in       : word to send, captured on the start edge
//   data_out      : serial data (MOSI), registered
//   clk_out       : serial clock (SCLK), registered
//   n_chip_enable : active-low chip select, registered
// Build option: SPI_SER_PENDING_EN adds a one-deep buffer that holds one
// request (0->1 edge of send_data) made while busy and launches it from GAP.
// -----------------------------------------------------------------------------
module spi_byte_serialiser
    import spi_ser_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int HALF_PERIOD = DEF_HALF_PERIOD
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  send_data,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  data_out,
    output logic                  clk_out,
    output logic                  n_chip_enable
);

    localparam int BIT_W = cnt_width(DATA_WIDTH);

    state_e                state_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [BIT_W-1:0]      count_q;
    logic                  data_out_q;
    logic                  clk_out_q;
    logic                  n_ce_q;

    logic                  tick;
    logic                  start;
    logic [DATA_WIDTH-1:0] start_data;

`ifdef SPI_SER_PENDING_EN
    logic                  pend_valid_q;
    logic [DATA_WIDTH-1:0] pend_data_q;
    logic                  send_q;
`endif

    // Decide whether a frame launches on this edge and which word it carries.
    always_comb begin
        // NOTE: defaults first, so no path leaves an output unassigned and
        // no latch is inferred.
        start      = 1'b0;
        start_data = data_in;
`ifdef SPI_SER_PENDING_EN
        if (state_q == IDLE) begin
            start = pend_valid_q || send_data;
        end else if (state_q == GAP) begin
            start = pend_valid_q;
        end
        if (pend_valid_q) begin
            start_data = pend_data_q;
        end
`else
        start = (state_q == IDLE) && send_data;
`endif
    end

    spi_half_period_timer #(
        .HALF_PERIOD (HALF_PERIOD)
    ) u_timer (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .clear_i (start),
        .en_i    ((state_q == SHIFT_LOW) || (state_q == SHIFT_HIGH)),
        .tick_o  (tick)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            count_q    <= '0;
            data_out_q <= 1'b0;
            clk_out_q  <= 1'b0;
            n_ce_q     <= 1'b1;
        end else if (start) begin
            // Only asserted from IDLE or GAP; both launch a frame the same way.
            state_q    <= SHIFT_LOW;
            shift_q    <= start_data;
            count_q    <= BIT_W'(DATA_WIDTH - 1);
            data_out_q <= start_data[DATA_WIDTH-1];
            clk_out_q  <= 1'b0;
            n_ce_q     <= 1'b0;
        end else begin
            case (state_q)
                SHIFT_LOW: begin
                    if (tick) begin
                        clk_out_q <= 1'b1;
                        state_q   <= SHIFT_HIGH;
                    end
                end
                SHIFT_HIGH: begin
                    if (tick) begin
                        clk_out_q <= 1'b0;
                        if (count_q != '0) begin
                            // Present the next bit on the falling SCLK edge.
                            shift_q    <= shift_q << 1;
                            data_out_q <= shift_q[DATA_WIDTH-2];
                            count_q    <= count_q - 1'b1;
                            state_q    <= SHIFT_LOW;
                        end else begin
                            n_ce_q     <= 1'b1;
                            data_out_q <= 1'b0;
                            state_q    <= GAP;
                        end
                    end
                end
                GAP:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef SPI_SER_PENDING_EN
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pend_valid_q <= 1'b0;
            pend_data_q  <= '0;
            send_q       <= 1'b0;
        end else begin
            send_q <= send_data;
            if (start && pend_valid_q) begin
                pend_valid_q <= 1'b0;
            end else if ((state_q != IDLE) && send_data && !send_q && !pend_valid_q) begin
                pend_valid_q <= 1'b1;
                pend_data_q  <= data_in;
            end
        end
    end
`endif

    assign data_out      = data_out_q;
    assign clk_out       = clk_out_q;
    assign n_chip_enable = n_ce_q;

endmodule

// File: tb/tb_spi_byte_serialiser.sv
// -----------------------------------------------------------------------------
// tb_spi_byte_serialiser
// Self-checking bench for spi_byte_serialiser (default parameters). A timing
// model derived from frame offsets predicts the three outputs after every
// clk_in edge; a bus monitor reassembles the bytes seen on rising SCLK edges
// for the directed scenarios. Honours SPI_SER_PENDING_EN when defined.
// -----------------------------------------------------------------------------
module tb_spi_byte_serialiser;

    localparam int W  = 8;
    localparam int HP = 1;
    localparam int SH = 2 * HP * W;   // cycles with chip enable low
    localparam int L  = SH + 2;       // start-to-start period

    logic         clk_in = 1'b0;
    logic         rst_in;
    logic         send_data;
    logic [W-1:0] data_in;
    logic         data_out;
    logic         clk_out;
    logic         n_chip_enable;

    spi_byte_serialiser #(
        .DATA_WIDTH  (W),
        .HALF_PERIOD (HP)
    ) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .send_data     (send_data),
        .data_in       (data_in),
        .data_out      (data_out),
        .clk_out       (clk_out),
        .n_chip_enable (n_chip_enable)
    );

    always #5 clk_in = ~clk_in;

    int vectors_applied = 0;
    int miscompares     = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors_applied++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int           t       = 0;
    int           e_start = -1000;
    bit           active  = 0;
    logic [W-1:0] m_byte  = '0;
`ifdef SPI_SER_PENDING_EN
    bit           pv        = 0;
    logic [W-1:0] pd        = '0;
    bit           prev_send = 0;
`endif

    // Apply the inputs seen at this rising edge to the model.
    task automatic model_edge();
        int           k;
        bit           idle;
        bit           st;
        logic [W-1:0] sd;
        t++;
        if (rst_in) begin
            active = 0;
`ifdef SPI_SER_PENDING_EN
            pv = 0;
            prev_send = 0;
`endif
            return;
        end
        k    = t - e_start;
        idle = !active || (k >= L);
        sd   = data_in;
`ifdef SPI_SER_PENDING_EN
        st = 0;
        if ((idle && (pv || send_data)) || (active && (k == L - 1) && pv)) begin
            st = 1;
            if (pv) sd = pd;
            pv = 0;
        end else if (!idle && send_data && !prev_send && !pv) begin
            pv = 1;
            pd = data_in;
        end
        prev_send = send_data;
`else
        st = idle && send_data;
`endif
        if (st) begin
            active  = 1;
            e_start = t;
            m_byte  = sd;
        end
    endtask

    // Expected {n_chip_enable, clk_out, data_out} after the latest edge.
    function automatic logic [2:0] model_out();
        int k;
        k = t - e_start;
        if (active && (k < SH)) begin
            return {1'b0, (((k / HP) % 2) == 1), m_byte[W - 1 - k / (2 * HP)]};
        end
        return 3'b100;
    endfunction

    // ---------------- bus monitor ----------------
    logic [W-1:0] frames[$];
    logic [W-1:0] mon_bits  = '0;
    int           mon_nbits = 0;
    int           low_len   = 0;
    int           high_len  = 0;
    int           last_low  = 0;
    int           last_gap  = 0;
    logic         prev_nce  = 1'b1;
    logic         prev_clk  = 1'b0;

    task automatic monitor();
        if (!n_chip_enable) begin
            if (prev_nce) begin
                last_gap  = high_len;
                mon_nbits = 0;
                low_len   = 0;
            end
            low_len++;
            high_len = 0;
            if (clk_out && !prev_clk) begin
                mon_bits = {mon_bits[W-2:0], data_out};
                mon_nbits++;
            end
        end else begin
            if (!prev_nce) begin
                if (mon_nbits == W) frames.push_back(mon_bits);
                last_low = low_len;
            end
            high_len++;
        end
        prev_nce = n_chip_enable;
        prev_clk = clk_out;
    endtask

    // One clk_in cycle: model update at the edge, compare 1 time unit later.
    task automatic cycle();
        @(posedge clk_in);
        model_edge();
        #1;
        check($sformatf("outs@%0d", t), {29'd0, n_chip_enable, clk_out, data_out},
              {29'd0, model_out()});
        monitor();
    endtask

    task automatic idle_cycles(input int n);
        send_data = 1'b0;
        repeat (n) cycle();
        frames.delete();
    endtask

    task automatic pulse(input logic [W-1:0] d);
        data_in   = d;
        send_data = 1'b1;
        cycle();
        send_data = 1'b0;
    endtask

    initial begin
        rst_in    = 1'b1;
        send_data = 1'b1;
        data_in   = 8'hFF;

        // 1. reset with send_data asserted: outputs stay idle
        repeat (2) cycle();
        check("reset_idle", {29'd0, n_chip_enable, clk_out, data_out}, 32'b100);
        rst_in = 1'b0;
        idle_cycles(3);

        // 2. single 0x76 frame
        pulse(8'h76);
        repeat (20) cycle();
        check("t2_frames", frames.size(), 1);
        if (frames.size() >= 1) check("t2_byte", frames[0], 8'h76);
        check("t2_nce_low", last_low, SH);
        idle_cycles(2);

        // 3. 0x9D with a second request 0x95 at cycle 7 of the frame
        pulse(8'h9D);
        repeat (6) cycle();
        pulse(8'h95);
        repeat (40) cycle();
`ifdef SPI_SER_PENDING_EN
        check("t3_frames", frames.size(), 2);
        if (frames.size() >= 2) begin
            check("t3_byte0", frames[0], 8'h9D);
            check("t3_byte1", frames[1], 8'h95);
        end
        check("t3_gap", last_gap, 1);
`else
        check("t3_frames", frames.size(), 1);
        if (frames.size() >= 1) check("t3_byte0", frames[0], 8'h9D);
`endif
        idle_cycles(2);

        // 4. send_data held 13 cycles; data_in changes mid-frame
        data_in   = 8'h95;
        send_data = 1'b1;
        for (int i = 0; i < 13; i++) begin
            if (i == 5) data_in = 8'hDD;
            cycle();
        end
        send_data = 1'b0;
        repeat (25) cycle();
        check("t4_frames", frames.size(), 1);
        if (frames.size() >= 1) check("t4_byte", frames[0], 8'h95);
        idle_cycles(2);

        // 5. send_data held 40 cycles: back-to-back frames at E, E+18, E+36
        data_in   = 8'hDD;
        send_data = 1'b1;
        repeat (40) cycle();
        send_data = 1'b0;
        repeat (25) cycle();
        check("t5_frames", frames.size(), 3);
        for (int i = 0; i < frames.size(); i++) check($sformatf("t5_byte%0d", i), frames[i], 8'hDD);
        check("t5_gap", last_gap, L - SH);
        idle_cycles(2);

        // 6. reset at cycle 5 of a 0xA5 frame, then a fresh frame
        pulse(8'hA5);
        repeat (4) cycle();
        rst_in = 1'b1;
        cycle();
        check("t6_abort", {29'd0, n_chip_enable, clk_out, data_out}, 32'b100);
        rst_in = 1'b0;
        repeat (2) cycle();
        pulse(8'hA5);
        repeat (20) cycle();
        check("t6_frames", frames.size(), 1);
        if (frames.size() >= 1) check("t6_byte", frames[0], 8'hA5);
        idle_cycles(2);

        // 7. randomized pulses, holds, data changes and resets
        for (int it = 0; it < 150; it++) begin
            int mode;
            mode    = int'($urandom_range(0, 9));
            data_in = W'($urandom);
            if (mode == 0) begin
                rst_in = 1'b1;
                cycle();
                rst_in = 1'b0;
            end else if (mode < 5) begin
                pulse(data_in);
                repeat ($urandom_range(0, 25)) begin
                    if ($urandom_range(0, 3) == 0) data_in = W'($urandom);
                    if ($urandom_range(0, 7) == 0) send_data = 1'b1;
                    cycle();
                    send_data = 1'b0;
                end
            end else begin
                send_data = 1'b1;
                repeat ($urandom_range(1, 45)) begin
                    if ($urandom_range(0, 3) == 0) data_in = W'($urandom);
                    cycle();
                end
                send_data = 1'b0;
                repeat ($urandom_range(0, 5)) cycle();
            end
        end
        idle_cycles(20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
